// File: rtl/mbisr_pkg.sv
// Shared constants, the repair table entry type and the one-hot encoder
// used by the repair-allocation stage behind the MBIST engine.
package mbisr_pkg;

    localparam int ADDR_W     = 6;
    localparam int NUM_SPARES = 4;
    localparam int IDX_W      = 2;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] addr;
    } repair_entry_t;

    // Entries are unique, so at most one bit is set; OR-ing the indices of
    // the set bits gives the matching index, or 0 when nothing matched.
    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [NUM_SPARES-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (oh[i]) begin
                idx = idx | IDX_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mbisr_repair_map_if.sv
// Bundle of control, fail-report, lookup and status signals between the
// MBIST/memory side (master) and the repair map (slave).
interface mbisr_repair_map_if;
    import mbisr_pkg::*;

    logic              clear;
    logic              lock;
    logic              fail_valid;
    logic [ADDR_W-1:0] fail_addr;
    logic              lookup_valid;
    logic [ADDR_W-1:0] lookup_addr;
    logic              remap_valid;
    logic              hit;
    logic [IDX_W-1:0]  hit_idx;
    logic [IDX_W:0]    repair_count;
    logic              repairable;

    modport master (
        output clear, lock, fail_valid, fail_addr, lookup_valid, lookup_addr,
        input  remap_valid, hit, hit_idx, repair_count, repairable
    );

    modport slave (
        input  clear, lock, fail_valid, fail_addr, lookup_valid, lookup_addr,
        output remap_valid, hit, hit_idx, repair_count, repairable
    );

endinterface

// File: rtl/mbisr_cam_entry.sv
// One repair table entry: a registered {valid, addr} with combinational
// compares against the incoming fail address and the lookup address.
module mbisr_cam_entry
    import mbisr_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] fail_addr,
    input  logic [ADDR_W-1:0] lookup_addr,
    output logic              match_fail,
    output logic              match_lookup
);

    repair_entry_t entry_q;
    repair_entry_t entry_d;

    // Next entry value: wipe on clear, capture the fail address on write.
    always_comb begin
        entry_d = entry_q;
        if (clr) begin
            entry_d = '0;
        end else if (we) begin
            entry_d.valid = 1'b1;
            entry_d.addr  = fail_addr;
        end
    end

    // Entry register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            entry_q <= '0;
        end else begin
            entry_q <= entry_d;
        end
    end

    assign match_fail   = entry_q.valid && (entry_q.addr == fail_addr);
    assign match_lookup = entry_q.valid && (entry_q.addr == lookup_addr);

endmodule

// File: rtl/mbisr_repair_map.sv
// Repair allocation: assigns each new failing address to the next free spare
// row, flags the array unrepairable once spares run out, and answers
// registered remap lookups against the pre-allocation table state.
module mbisr_repair_map
    import mbisr_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    mbisr_repair_map_if.slave         bus
);

    localparam logic [IDX_W:0] SPARE_CNT = (IDX_W+1)'(NUM_SPARES);

    logic [NUM_SPARES-1:0] match_fail;
    logic [NUM_SPARES-1:0] match_lookup;
    logic [NUM_SPARES-1:0] we_vec;

    logic [IDX_W:0]   count_q, count_d;
    logic             repairable_q, repairable_d;
    logic             remap_valid_q, remap_valid_d;
    logic             hit_q, hit_d;
    logic [IDX_W-1:0] hit_idx_q, hit_idx_d;

    for (genvar g = 0; g < NUM_SPARES; g++) begin : g_entry
        mbisr_cam_entry u_entry (
            .clk          (clk),
            .rst          (rst),
            .clr          (bus.clear),
            .we           (we_vec[g]),
            .fail_addr    (bus.fail_addr),
            .lookup_addr  (bus.lookup_addr),
            .match_fail   (match_fail[g]),
            .match_lookup (match_lookup[g])
        );
    end

    // Allocation: duplicates are dropped, new addresses take the next slot,
    // and a new address with no slot left makes the array unrepairable.
    always_comb begin
        count_d      = count_q;
        repairable_d = repairable_q;
        we_vec       = '0;
        if (bus.clear) begin
            count_d      = '0;
            repairable_d = 1'b1;
        end else if (bus.fail_valid && !bus.lock && !(|match_fail)) begin
            if (count_q < SPARE_CNT) begin
                we_vec[count_q[IDX_W-1:0]] = 1'b1;
                count_d                    = count_q + (IDX_W+1)'(1);
            end else begin
                repairable_d = 1'b0;
            end
        end
    end

    // Lookup result for the next cycle; zeroed whenever no lookup was made.
    always_comb begin
        remap_valid_d = bus.lookup_valid;
        hit_d         = bus.lookup_valid && (|match_lookup);
        hit_idx_d     = bus.lookup_valid ? onehot_to_idx(match_lookup) : '0;
    end

    // Status and lookup registers; clear leaves the lookup pipeline alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            repairable_q  <= 1'b1;
            remap_valid_q <= 1'b0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
        end else begin
            count_q       <= count_d;
            repairable_q  <= repairable_d;
            remap_valid_q <= remap_valid_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
        end
    end

    assign bus.repair_count = count_q;
    assign bus.repairable   = repairable_q;
    assign bus.remap_valid  = remap_valid_q;
    assign bus.hit          = hit_q;
    assign bus.hit_idx      = hit_idx_q;

endmodule

// File: tb/tb_mbisr_repair_map.sv
// Bench for mbisr_repair_map: a behavioural table model predicts lookup
// results (queued at drive time, popped when remap_valid appears) and the
// count/repairable status after every cycle.
module tb_mbisr_repair_map;
    import mbisr_pkg::*;

    logic clk = 1'b0;
    logic rst;

    mbisr_repair_map_if bus();

    mbisr_repair_map dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [IDX_W:0] exp_q[$];

    bit               m_valid [NUM_SPARES];
    logic [ADDR_W-1:0] m_addr [NUM_SPARES];
    int               m_cnt;
    bit               m_rep;

    task automatic model_reset();
        for (int i = 0; i < NUM_SPARES; i++) begin
            m_valid[i] = 1'b0;
            m_addr[i]  = '0;
        end
        m_cnt = 0;
        m_rep = 1'b1;
    endtask

    task automatic model_lookup(input logic [ADDR_W-1:0] a, output bit h, output logic [IDX_W-1:0] idx);
        h   = 1'b0;
        idx = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            if (m_valid[i] && m_addr[i] == a) begin
                h   = 1'b1;
                idx = IDX_W'(i);
            end
        end
    endtask

    task automatic model_update();
        bit dup;
        dup = 1'b0;
        if (rst || bus.clear) begin
            model_reset();
        end else if (bus.fail_valid && !bus.lock) begin
            for (int i = 0; i < NUM_SPARES; i++) begin
                if (m_valid[i] && m_addr[i] == bus.fail_addr) dup = 1'b1;
            end
            if (!dup) begin
                if (m_cnt < NUM_SPARES) begin
                    m_valid[m_cnt] = 1'b1;
                    m_addr[m_cnt]  = bus.fail_addr;
                    m_cnt++;
                end else begin
                    m_rep = 1'b0;
                end
            end
        end
    endtask

    // Advance one clock: queue the expected lookup result from the table as it
    // stands this cycle, then apply this cycle's inputs to the model.
    task automatic cycle();
        bit               eh;
        logic [IDX_W-1:0] ei;
        if (bus.lookup_valid && !rst) begin
            model_lookup(bus.lookup_addr, eh, ei);
            exp_q.push_back({eh, ei});
        end
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.clear        = 1'b0;
        bus.lock         = 1'b0;
        bus.fail_valid   = 1'b0;
        bus.fail_addr    = '0;
        bus.lookup_valid = 1'b0;
        bus.lookup_addr  = '0;
    endtask

    task automatic fail(input logic [ADDR_W-1:0] a);
        idle_inputs();
        bus.fail_valid = 1'b1;
        bus.fail_addr  = a;
        cycle();
        idle_inputs();
    endtask

    task automatic pulse_clear();
        idle_inputs();
        bus.clear = 1'b1;
        cycle();
        idle_inputs();
    endtask

    task automatic lookup_check(input logic [ADDR_W-1:0] a, input bit req_hit,
                                input logic [IDX_W-1:0] req_idx, input string name);
        logic [IDX_W:0] e;
        idle_inputs();
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = a;
        cycle();
        idle_inputs();
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        total++;
        if (bus.remap_valid !== 1'b1) begin
            bad++;
            $display("FAIL %s remap_valid got=%b want=1", name, bus.remap_valid);
        end
        total++;
        if (bus.hit !== e[IDX_W] || bus.hit_idx !== e[IDX_W-1:0]) begin
            bad++;
            $display("FAIL %s model hit/idx got=%b/%0d want=%b/%0d", name, bus.hit, bus.hit_idx, e[IDX_W], e[IDX_W-1:0]);
        end
        total++;
        if (bus.hit !== req_hit || bus.hit_idx !== req_idx) begin
            bad++;
            $display("FAIL %s plan hit/idx got=%b/%0d want=%b/%0d", name, bus.hit, bus.hit_idx, req_hit, req_idx);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        total++;
        if (bus.remap_valid !== 1'b0 || bus.hit !== 1'b0 || bus.hit_idx !== '0) begin
            bad++;
            $display("FAIL reset_lookup got rv=%b hit=%b idx=%0d want 0/0/0", bus.remap_valid, bus.hit, bus.hit_idx);
        end
        total++;
        if (bus.repair_count !== '0 || bus.repairable !== 1'b1) begin
            bad++;
            $display("FAIL reset_status got cnt=%0d rep=%b want 0/1", bus.repair_count, bus.repairable);
        end
    endtask

    task automatic test_single_fault();
        pulse_clear();
        fail(6'd8);
        lookup_check(6'd8, 1'b1, 2'd0, "single_hit8");
        total++;
        if (bus.repair_count !== 3'd1 || bus.repairable !== 1'b1) begin
            bad++;
            $display("FAIL single_status got cnt=%0d rep=%b want 1/1", bus.repair_count, bus.repairable);
        end
        lookup_check(6'd9, 1'b0, 2'd0, "single_miss9");
        cycle();
        total++;
        if (bus.remap_valid !== 1'b0 || bus.hit !== 1'b0 || bus.hit_idx !== '0) begin
            bad++;
            $display("FAIL idle_outputs got rv=%b hit=%b idx=%0d want 0/0/0", bus.remap_valid, bus.hit, bus.hit_idx);
        end
    endtask

    task automatic test_duplicate();
        pulse_clear();
        fail(6'd42);
        fail(6'd42);
        fail(6'd42);
        total++;
        if (bus.repair_count !== 3'd1) begin
            bad++;
            $display("FAIL dup_count got=%0d want=1", bus.repair_count);
        end
        lookup_check(6'd42, 1'b1, 2'd0, "dup_hit42");
    endtask

    task automatic test_overflow();
        pulse_clear();
        fail(6'd8);
        fail(6'd42);
        fail(6'd3);
        fail(6'd63);
        total++;
        if (bus.repair_count !== 3'd4 || bus.repairable !== 1'b1) begin
            bad++;
            $display("FAIL ovf_full got cnt=%0d rep=%b want 4/1", bus.repair_count, bus.repairable);
        end
        fail(6'd17);
        total++;
        if (bus.repair_count !== 3'd4 || bus.repairable !== 1'b0) begin
            bad++;
            $display("FAIL ovf_over got cnt=%0d rep=%b want 4/0", bus.repair_count, bus.repairable);
        end
        fail(6'd42);
        total++;
        if (bus.repair_count !== 3'd4 || bus.repairable !== 1'b0) begin
            bad++;
            $display("FAIL ovf_sticky got cnt=%0d rep=%b want 4/0", bus.repair_count, bus.repairable);
        end
        lookup_check(6'd17, 1'b0, 2'd0, "ovf_miss17");
        lookup_check(6'd63, 1'b1, 2'd3, "ovf_hit63");
        lookup_check(6'd3,  1'b1, 2'd2, "ovf_hit3");
        lookup_check(6'd42, 1'b1, 2'd1, "ovf_hit42");
    endtask

    task automatic test_rerun();
        pulse_clear();
        total++;
        if (bus.repair_count !== '0 || bus.repairable !== 1'b1) begin
            bad++;
            $display("FAIL rerun_status got cnt=%0d rep=%b want 0/1", bus.repair_count, bus.repairable);
        end
        lookup_check(6'd8, 1'b0, 2'd0, "rerun_miss8");
        fail(6'd42);
        lookup_check(6'd42, 1'b1, 2'd0, "rerun_hit42");
    endtask

    task automatic test_priority();
        pulse_clear();
        idle_inputs();
        bus.fail_valid   = 1'b1;
        bus.fail_addr    = 6'd8;
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = 6'd8;
        cycle();
        idle_inputs();
        total++;
        if (bus.remap_valid !== 1'b1 || bus.hit !== 1'b0 || exp_q.size() != 1) begin
            bad++;
            $display("FAIL same_cycle got rv=%b hit=%b want rv=1 hit=0", bus.remap_valid, bus.hit);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        lookup_check(6'd8, 1'b1, 2'd0, "next_cycle_hit8");

        pulse_clear();
        idle_inputs();
        bus.clear      = 1'b1;
        bus.fail_valid = 1'b1;
        bus.fail_addr  = 6'd5;
        cycle();
        idle_inputs();
        total++;
        if (bus.repair_count !== '0) begin
            bad++;
            $display("FAIL clear_vs_fail count got=%0d want=0", bus.repair_count);
        end
        lookup_check(6'd5, 1'b0, 2'd0, "clear_vs_fail_miss5");

        fail(6'd1);
        idle_inputs();
        bus.lock       = 1'b1;
        bus.fail_valid = 1'b1;
        bus.fail_addr  = 6'd7;
        cycle();
        idle_inputs();
        total++;
        if (bus.repair_count !== 3'd1) begin
            bad++;
            $display("FAIL lock_count got=%0d want=1", bus.repair_count);
        end
        lookup_check(6'd7, 1'b0, 2'd0, "lock_miss7");

        // A lookup registered just before a clear still reports the old table.
        idle_inputs();
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = 6'd1;
        cycle();
        idle_inputs();
        bus.clear = 1'b1;
        total++;
        if (bus.remap_valid !== 1'b1 || bus.hit !== 1'b1 || bus.hit_idx !== 2'd0) begin
            bad++;
            $display("FAIL lookup_before_clear got rv=%b hit=%b idx=%0d want 1/1/0", bus.remap_valid, bus.hit, bus.hit_idx);
        end
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        cycle();
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [IDX_W:0] e;
        bit             exp_rv;
        pulse_clear();
        for (int c = 0; c < 80; c++) begin
            bus.clear        = ($urandom_range(0, 19) == 0);
            bus.lock         = ($urandom_range(0, 5) == 0);
            bus.fail_valid   = ($urandom_range(0, 1) == 1);
            bus.fail_addr    = ADDR_W'($urandom_range(0, 7));
            bus.lookup_valid = ($urandom_range(0, 2) != 0);
            bus.lookup_addr  = ADDR_W'($urandom_range(0, 7));
            cycle();
            exp_rv = (exp_q.size() > 0);
            e = exp_rv ? exp_q.pop_front() : '0;
            total++;
            if (bus.remap_valid !== exp_rv || bus.hit !== e[IDX_W] || bus.hit_idx !== e[IDX_W-1:0]) begin
                bad++;
                $display("FAIL b2b_lookup c=%0d got rv=%b hit=%b idx=%0d want %b/%b/%0d",
                         c, bus.remap_valid, bus.hit, bus.hit_idx, exp_rv, e[IDX_W], e[IDX_W-1:0]);
            end
            total++;
            if (bus.repair_count !== (IDX_W+1)'(m_cnt) || bus.repairable !== m_rep) begin
                bad++;
                $display("FAIL b2b_status c=%0d got cnt=%0d rep=%b want %0d/%b",
                         c, bus.repair_count, bus.repairable, m_cnt, m_rep);
            end
        end
        idle_inputs();
        cycle();
        exp_q.delete();
    endtask

    task automatic test_reset_mid_lookup();
        pulse_clear();
        fail(6'd8);
        fail(6'd9);
        idle_inputs();
        bus.lookup_valid = 1'b1;
        bus.lookup_addr  = 6'd8;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        idle_inputs();
        total++;
        if (bus.remap_valid !== 1'b0 || bus.repair_count !== '0 || bus.repairable !== 1'b1) begin
            bad++;
            $display("FAIL reset_mid_lookup got rv=%b cnt=%0d rep=%b want 0/0/1", bus.remap_valid, bus.repair_count, bus.repairable);
        end
        lookup_check(6'd8, 1'b0, 2'd0, "reset_discards_table");
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_reset();
        test_reset();
        test_single_fault();
        test_duplicate();
        test_overflow();
        test_rerun();
        test_priority();
        test_back_to_back();
        test_reset_mid_lookup();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mbisr_repair_map.md
Name: mbisr_repair_map

Overview:
- Repair-allocation stage directly downstream of the MBIST engine in tt_hp_um_aksp_mbist_mbisr.
- Captures each failing address the MBIST engine reports and assigns it to one of NUM_SPARES spare rows.
- Serves registered remap lookups to the memory access path.
- Reports whether the array is still repairable.

Parameters:
ADDR_W, 6, memory address width (64-entry array)
NUM_SPARES, 4, number of spare rows / repair table entries
IDX_W, 2, spare index width, equal to clog2(NUM_SPARES)

Ports:
clk  input  1  system clock
rst  input  1  synchronous reset, active-high
clear  input  1  wipe repair table (pulsed at MBIST start)
lock  input  1  freeze table; fail reports ignored while high
fail_valid  input  1  MBIST reports a failing address this cycle
fail_addr  input  ADDR_W  failing address
lookup_valid  input  1  functional access requests remap check
lookup_addr  input  ADDR_W  address to check
remap_valid  output  1  lookup result valid (1 cycle after lookup_valid)
hit  output  1  lookup_addr is mapped to a spare
hit_idx  output  IDX_W  spare index on hit, 0 on miss
repair_count  output  IDX_W+1  number of allocated spares, 0..NUM_SPARES
repairable  output  1  0 once a failure could not be allocated (sticky)

Behaviour:
- Clock and reset:
  - Single clock domain (clk). Reset is synchronous and active-high on rst.
  - Reset values: all entries invalid, addresses 0, repair_count=0, repairable=1, remap_valid=0, hit=0, hit_idx=0.
- Clear:
  - clear=1 has the same effect on the table, count and repairable as rst.
  - clear does not affect a lookup already registered in the previous cycle.
  - clear has priority over fail_valid in the same cycle.
- Allocation, evaluated each cycle with fail_valid=1, lock=0, clear=0:
  - fail_addr matches a valid entry: no change (duplicate; MBIST reports the same address on several march elements).
  - Else, if repair_count < NUM_SPARES: entry[repair_count] <= {valid=1, fail_addr}; repair_count++.
  - Else: repairable <= 0. Sticky until rst or clear. The table is unchanged.
  - lock=1: fail_valid is ignored entirely. repairable and count are unchanged.
- Lookup:
  - One-cycle latency. remap_valid(t+1) = lookup_valid(t).
  - Compare against the table state at cycle t, before any allocation written at the edge ending t.
  - A same-cycle fail and lookup of the same address therefore yields a miss.
  - On a miss: hit=0, hit_idx=0.
  - Entries are unique by construction, so at most one match exists. hit_idx is its index.
  - The hit/hit_idx values are defined only when remap_valid=1. When remap_valid=0 they are driven to 0.
- Entry ordering: entries fill in index order 0..NUM_SPARES-1. There is no wrap-around and no replacement.
- Width rule: repair_count saturates at NUM_SPARES and never overflows into IDX_W+1 bits.
- Reset mid-operation: rst during a pending lookup drops remap_valid to 0 in the next cycle. A partially built table is discarded.

Decomposition:
- Shared package mbisr_pkg holds:
  - ADDR_W, NUM_SPARES and IDX_W constants.
  - typedef repair_entry_t {logic valid; logic [ADDR_W-1:0] addr}.
- Sub-module mbisr_cam_entry:
  - Holds one entry register.
  - Has a write-enable port.
  - Provides two combinational compare outputs: match_fail for duplicate detection and match_lookup for remap.
- Top level instantiates NUM_SPARES entries and contains:
  - the allocation counter and repairable flag;
  - the one-hot to index encode;
  - the lookup output register.

Test Plan:
- Single fault: reset, clear, then fail_valid with addr 8, then lookup addr 8.
  - Required: remap_valid=1, hit=1, hit_idx=0, repair_count=1, repairable=1.
  - Lookup addr 9 afterwards: hit=0, hit_idx=0.
- Duplicate suppression: report addr 42 three times on consecutive cycles.
  - Required: repair_count=1, entry 0 holds 42.
  - Lookup 42: hit_idx=0.
- Overflow: report 8, 42, 3, 63, 17.
  - After 4 reports: repair_count=4, repairable=1.
  - After the 5th: repairable=0, repair_count stays 4.
  - Lookup 17: miss. Lookup 63: hit_idx=3.
- Re-run: after the overflow case, pulse clear.
  - Required: repair_count=0, repairable=1, lookup 8 misses.
  - Then report 42: lookup 42 gives hit_idx=0.
- Simultaneous and priority events:
  - Same-cycle fail_valid and lookup of addr 8 on an empty table: lookup returns hit=0.
  - Next-cycle lookup of addr 8: hit=1.
  - Same-cycle clear and fail_valid(5): table empty afterwards.
  - lock=1 with fail_valid(7): repair_count unchanged.
- Reset mid-lookup: assert lookup_valid and rst together.
  - Next cycle: remap_valid=0, repair_count=0.
